// File: rtl/aes_seq_ctrl.sv
// Byte-serial sequencer for the encoder/decoder core: gathers a 16-bit block and key
// from two byte pairs, steps the core through its rounds and hands the result downstream.
module aes_seq_ctrl #(
   parameter int NUM_ROUNDS = 4,
   parameter int ROUND_W    = 4
) (
   input  logic               in_clk,
   input  logic               in_restart_n,
   input  logic               in_enable_encode,
   input  logic               in_valid,
   output logic               out_ready,
   input  logic [7:0]         in_d_in,
   input  logic [7:0]         in_key_in,
   output logic               out_core_start,
   output logic               out_core_mode,
   output logic               out_core_round_en,
   output logic [ROUND_W-1:0] out_core_round,
   output logic [15:0]        out_core_block,
   output logic [15:0]        out_core_key,
   input  logic [15:0]        in_core_result,
   output logic               out_valid,
   input  logic               in_ready,
   output logic [15:0]        out_data,
   output logic               out_busy
);

   // state    | meaning
   // ---------+--------------------------------------------------------------
   // S_IDLE   | waiting for the first (high) byte pair; latches mode
   // S_LOAD_LO| waiting for the second (low) byte pair, no timeout
   // S_START  | one-cycle core load pulse, round index preset
   // S_ROUND  | NUM_ROUNDS round strobes, index counts up (enc) or down (dec)
   // S_CAPTURE| core result registered into out_data
   // S_DONE   | result presented until downstream accepts
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_LO,
      S_START,
      S_ROUND,
      S_CAPTURE,
      S_DONE
   } state_t;

   localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(NUM_ROUNDS - 1);

   state_t             state;
   state_t             state_nxt;
   logic [15:0]        block_q;
   logic [15:0]        key_q;
   logic [15:0]        data_q;
   logic               mode_q;
   logic [ROUND_W-1:0] round_q;
   logic               accept;
   logic               last_round;

   assign out_ready  = (state == S_IDLE) || (state == S_LOAD_LO);
   assign accept     = in_valid && out_ready;
   // Termination is on the index itself so the counter never steps past either end.
   assign last_round = mode_q ? (round_q == LAST_IDX) : (round_q == '0);

   always_ff @(posedge in_clk) begin
      if (!in_restart_n) begin
         state   <= S_IDLE;
         block_q <= '0;
         key_q   <= '0;
         data_q  <= '0;
         mode_q  <= 1'b0;
         round_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  block_q[15:8] <= in_d_in;
                  key_q[15:8]   <= in_key_in;
                  mode_q        <= in_enable_encode;
               end
            end
            S_LOAD_LO: begin
               if (accept) begin
                  block_q[7:0] <= in_d_in;
                  key_q[7:0]   <= in_key_in;
               end
            end
            S_START: begin
               round_q <= mode_q ? '0 : LAST_IDX;
            end
            S_ROUND: begin
               if (!last_round) begin
                  round_q <= mode_q ? round_q + 1'b1 : round_q - 1'b1;
               end
            end
            S_CAPTURE: begin
               data_q <= in_core_result;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      state_nxt         = state;
      out_core_start    = 1'b0;
      out_core_round_en = 1'b0;
      out_valid         = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) state_nxt = S_LOAD_LO;
         end
         S_LOAD_LO: begin
            if (accept) state_nxt = S_START;
         end
         S_START: begin
            out_core_start = 1'b1;
            state_nxt      = S_ROUND;
         end
         S_ROUND: begin
            out_core_round_en = 1'b1;
            if (last_round) state_nxt = S_CAPTURE;
         end
         S_CAPTURE: begin
            state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (in_ready) state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign out_core_round = out_core_round_en ? round_q : '0;
   assign out_core_mode  = mode_q;
   assign out_core_block = block_q;
   assign out_core_key   = key_q;
   assign out_data       = data_q;
   assign out_busy       = (state != S_IDLE);

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Testbench for aes_seq_ctrl: table of directed blocks, a reset-abort sequence and
// randomized blocks checked cycle by cycle against a timeline model.
module tb_aes_seq_ctrl;

   localparam int N  = 4;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          in_restart_n = 1'b0;
   logic          in_enable_encode = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready;
   logic [7:0]    in_d_in = '0;
   logic [7:0]    in_key_in = '0;
   logic          out_core_start;
   logic          out_core_mode;
   logic          out_core_round_en;
   logic [RW-1:0] out_core_round;
   logic [15:0]   out_core_block;
   logic [15:0]   out_core_key;
   logic [15:0]   in_core_result = '0;
   logic          out_valid;
   logic          in_ready = 1'b0;
   logic [15:0]   out_data;
   logic          out_busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   aes_seq_ctrl #(.NUM_ROUNDS(N), .ROUND_W(RW)) dut (
      .in_clk            (clk),
      .in_restart_n      (in_restart_n),
      .in_enable_encode  (in_enable_encode),
      .in_valid          (in_valid),
      .out_ready         (out_ready),
      .in_d_in           (in_d_in),
      .in_key_in         (in_key_in),
      .out_core_start    (out_core_start),
      .out_core_mode     (out_core_mode),
      .out_core_round_en (out_core_round_en),
      .out_core_round    (out_core_round),
      .out_core_block    (out_core_block),
      .out_core_key      (out_core_key),
      .in_core_result    (in_core_result),
      .out_valid         (out_valid),
      .in_ready          (in_ready),
      .out_data          (out_data),
      .out_busy          (out_busy)
   );

   typedef struct {
      bit          mode;
      logic [7:0]  d0, k0, d1, k1;
      logic [15:0] res;
      int          stall;
      int          bp;
      bit          toggle;
      logic [15:0] exp_block;
      logic [15:0] exp_key;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_ready"}, 32'(out_ready), 1);
      chk({tag, "_busy"},  32'(out_busy), 0);
      chk({tag, "_valid"}, 32'(out_valid), 0);
      chk({tag, "_start"}, 32'(out_core_start), 0);
      chk({tag, "_ren"},   32'(out_core_round_en), 0);
      chk({tag, "_round"}, 32'(out_core_round), 0);
      chk({tag, "_mode"},  32'(out_core_mode), 0);
      chk({tag, "_block"}, 32'(out_core_block), 0);
      chk({tag, "_key"},   32'(out_core_key), 0);
      chk({tag, "_data"},  32'(out_data), 0);
   endtask

   // After the accept edge of the second pair (j = 0) the model timeline is:
   // j=0 start pulse, j=1..N rounds, j=N+1 result sampled, j=N+2 out_valid.
   task automatic run_block(input bit mode, input logic [7:0] d0, input logic [7:0] k0,
                            input logic [7:0] d1, input logic [7:0] k1,
                            input logic [15:0] res, input int stall, input int bp,
                            input bit toggle, input logic [15:0] exp_block,
                            input logic [15:0] exp_key, input int abort_at);
      int exp_round;
      bit exp_en;
      chk("idle_ready", 32'(out_ready), 1);
      chk("idle_busy",  32'(out_busy), 0);
      in_valid = 1'b1; in_d_in = d0; in_key_in = k0; in_enable_encode = mode;
      step();
      chk("lo_ready", 32'(out_ready), 1);
      chk("lo_busy",  32'(out_busy), 1);
      chk("lo_start", 32'(out_core_start), 0);
      in_enable_encode = toggle ? ~mode : mode;
      for (int s = 0; s < stall; s++) begin
         in_valid  = 1'b0;
         in_d_in   = 8'($urandom);
         in_key_in = 8'($urandom);
         step();
         chk("stall_start", 32'(out_core_start), 0);
         chk("stall_ready", 32'(out_ready), 1);
         chk("stall_busy",  32'(out_busy), 1);
      end
      in_valid = 1'b1; in_d_in = d1; in_key_in = k1;
      step();
      chk("start_pulse", 32'(out_core_start), 1);
      chk("start_block", 32'(out_core_block), 32'(exp_block));
      chk("start_key",   32'(out_core_key), 32'(exp_key));
      chk("start_mode",  32'(out_core_mode), 32'(mode));
      chk("start_ready", 32'(out_ready), 0);
      chk("start_ren",   32'(out_core_round_en), 0);
      in_valid = 1'b0;
      in_d_in = 8'($urandom); in_key_in = 8'($urandom);
      in_enable_encode = 1'($urandom);
      in_core_result = 16'($urandom);
      for (int j = 1; j <= N + 2; j++) begin
         step();
         exp_en    = (j >= 1) && (j <= N);
         exp_round = exp_en ? (mode ? j - 1 : N - j) : 0;
         chk("seq_ren",   32'(out_core_round_en), 32'(exp_en));
         chk("seq_round", 32'(out_core_round), 32'(exp_round));
         chk("seq_start", 32'(out_core_start), 0);
         chk("seq_valid", 32'(out_valid), 32'(j == N + 2));
         chk("seq_busy",  32'(out_busy), 1);
         chk("seq_block", 32'(out_core_block), 32'(exp_block));
         chk("seq_key",   32'(out_core_key), 32'(exp_key));
         chk("seq_mode",  32'(out_core_mode), 32'(mode));
         if (j == abort_at) begin
            in_restart_n = 1'b0;
            step();
            chk_cleared("abort");
            in_restart_n = 1'b1;
            for (int c = 0; c < 3 * N; c++) begin
               step();
               chk("abort_valid", 32'(out_valid), 0);
               chk("abort_busy",  32'(out_busy), 0);
            end
            return;
         end
         in_core_result = (j == N + 1) ? res : 16'($urandom);
      end
      chk("done_data", 32'(out_data), 32'(res));
      in_ready = 1'b0;
      in_valid = 1'b1;
      for (int b = 0; b < bp; b++) begin
         in_d_in = 8'($urandom); in_key_in = 8'($urandom);
         in_core_result = 16'($urandom);
         step();
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_data",  32'(out_data), 32'(res));
         chk("bp_ready", 32'(out_ready), 0);
         chk("bp_block", 32'(out_core_block), 32'(exp_block));
      end
      in_ready = 1'b1;
      step();
      chk("ret_valid", 32'(out_valid), 0);
      chk("ret_busy",  32'(out_busy), 0);
      chk("ret_ready", 32'(out_ready), 1);
      in_ready = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 8'h6F, 8'hA7, 8'h6B, 8'h3B, 16'h1234, 0, 0, 1'b0, 16'h6F6B, 16'hA73B};
      vecs[1] = '{1'b0, 8'h7A, 8'hA7, 8'hF5, 8'h3B, 16'hBEEF, 0, 0, 1'b1, 16'h7AF5, 16'hA73B};
      vecs[2] = '{1'b1, 8'h01, 8'h80, 8'hFE, 8'h7F, 16'hC0DE, 0, 5, 1'b0, 16'h01FE, 16'h807F};
      vecs[3] = '{1'b0, 8'h55, 8'hAA, 8'h00, 8'hFF, 16'h0F0F, 10, 2, 1'b0, 16'h5500, 16'hAAFF};

      in_restart_n = 1'b0;
      step();
      step();
      in_restart_n = 1'b1;
      chk_cleared("reset");
      step();
      chk_cleared("post_reset");

      foreach (vecs[i])
         run_block(vecs[i].mode, vecs[i].d0, vecs[i].k0, vecs[i].d1, vecs[i].k1,
                   vecs[i].res, vecs[i].stall, vecs[i].bp, vecs[i].toggle,
                   vecs[i].exp_block, vecs[i].exp_key, 0);

      // Reset while the round index shows 2, then a fresh block must still complete.
      run_block(1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 16'h5555, 0, 0, 1'b0,
                16'h1133, 16'h2244, 3);
      run_block(1'b0, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 16'hA5A5, 1, 1, 1'b1,
                16'hDEBE, 16'hADEF, 0);

      for (int r = 0; r < 20; r++) begin
         logic [7:0]  d0, k0, d1, k1;
         logic [15:0] res;
         bit          m;
         d0 = 8'($urandom); k0 = 8'($urandom);
         d1 = 8'($urandom); k1 = 8'($urandom);
         res = 16'($urandom);
         m = 1'($urandom);
         run_block(m, d0, k0, d1, k1, res, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 1'($urandom), {d0, d1}, {k0, k1}, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
